// File: rtl/md_ctrl_if.sv
// Request/status bundle shared by the E stage, md_ctrl and the multi-cycle mult/div unit.
interface md_ctrl_if #(
  parameter int CW = 6
);
  logic          md_req_E;
  logic [2:0]    md_op_E;
  logic          hilo_rd_E;
  logic          flush_E;
  logic          md_run;
  logic          md_start;
  logic [2:0]    md_op;
  logic          md_stall;
  logic          md_busy;
  logic [CW-1:0] md_cycles;
  logic          md_err;

  modport master (
    output md_req_E, md_op_E, hilo_rd_E, flush_E, md_run,
    input  md_start, md_op, md_stall, md_busy, md_cycles, md_err
  );

  modport slave (
    input  md_req_E, md_op_E, hilo_rd_E, flush_E, md_run,
    output md_start, md_op, md_stall, md_busy, md_cycles, md_err
  );
endinterface

// File: rtl/md_ctrl.sv
// Mult/div sequencer: one-cycle start, IDLE/ARM/BUSY tracking, pipeline stall and latency capture.
// Optional watchdog abort of a hung unit is enabled by defining MD_TIMEOUT_EN.
module md_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int CW         = 6
) (
  input  logic     clk,
  input  logic     reset,
  md_ctrl_if.slave bus
);

`ifdef MD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cycles_q;
  logic [2:0]    op_q;
  logic          busy_q;
  logic          err_q;
  logic          start;
  logic          stall;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) return v;
    return v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  assign cnt_d = sat_inc(cnt_q);

  // Gated by reset so no start pulse leaks out while the controller is held in reset.
  assign start = reset && (state_q == IDLE) && bus.md_req_E && !bus.flush_E;
  assign stall = (state_q != IDLE) && (bus.hilo_rd_E || bus.md_req_E);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cycles_q <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= bus.md_op_E;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        // md_run is ignored here: the unit raises it one cycle after start.
        ARM: begin
          cnt_q   <= cnt_d;
          state_q <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_d;
          if (!bus.md_run) begin
            cycles_q <= cnt_d;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (TMO_EN && (cnt_d == MAX_C)) begin
            err_q    <= 1'b1;
            cycles_q <= MAX_C;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.md_start  = start;
  assign bus.md_stall  = stall;
  assign bus.md_op     = op_q;
  assign bus.md_busy   = busy_q;
  assign bus.md_cycles = cycles_q;
  assign bus.md_err    = err_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl; with MD_TIMEOUT_EN it builds the DUT with MAX_CYCLES=8.
module tb_md_ctrl;

`ifdef MD_TIMEOUT_EN
  localparam int MAXC = 8;
`else
  localparam int MAXC = 40;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  md_ctrl_if #(.CW(6)) bus();

  md_ctrl #(.MAX_CYCLES(MAXC), .CW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.md_req_E  = 1'b0;
    bus.md_op_E   = 3'b000;
    bus.hilo_rd_E = 1'b0;
    bus.flush_E   = 1'b0;
    bus.md_run    = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    quiet_inputs();
    bus.md_req_E  = 1'b1;
    bus.md_op_E   = 3'b111;
    bus.hilo_rd_E = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.md_start, bus.md_stall, bus.md_busy, bus.md_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000", {bus.md_start, bus.md_stall, bus.md_busy, bus.md_err});
    end
    checks++;
    if (bus.md_op !== 3'b000) begin
      failures++;
      $display("FAIL reset_op got=%b want=000", bus.md_op);
    end
    checks++;
    if (bus.md_cycles !== 6'd0) begin
      failures++;
      $display("FAIL reset_cycles got=%0d want=0", bus.md_cycles);
    end
    quiet_inputs();
    @(negedge clk);
    reset = 1'b1;
    nxt();
  endtask

  task automatic test_basic_mult();
    int busy_n = 0, start_n = 0, stall_n = 0;
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b011;
    @(negedge clk);
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_stall !== 1'b0) begin
      failures++;
      $display("FAIL basic_start got start=%b stall=%b want start=1 stall=0", bus.md_start, bus.md_stall);
    end
    nxt();
    bus.md_req_E = 1'b0;
    bus.md_op_E  = 3'b000;
    for (int c = 1; c <= 40; c++) begin
      bus.md_run = (c <= 32);
      @(negedge clk);
      if (bus.md_busy)  busy_n++;
      if (bus.md_start) start_n++;
      if (bus.md_stall) stall_n++;
      nxt();
    end
    checks++;
    if (busy_n !== 33) begin
      failures++;
      $display("FAIL basic_busy_len got=%0d want=33", busy_n);
    end
    checks++;
    if (start_n !== 0 || stall_n !== 0) begin
      failures++;
      $display("FAIL basic_extra got starts=%0d stalls=%0d want 0 0", start_n, stall_n);
    end
    checks++;
    if (bus.md_op !== 3'b011) begin
      failures++;
      $display("FAIL basic_op got=%b want=011", bus.md_op);
    end
    checks++;
    if (bus.md_cycles !== 6'd33) begin
      failures++;
      $display("FAIL basic_cycles got=%0d want=33", bus.md_cycles);
    end
  endtask

  task automatic test_stalled_mfhi();
    int start_n = 0;
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b010;
    nxt();
    bus.md_req_E = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      bus.md_run    = (c <= 10);
      bus.hilo_rd_E = (c >= 3);
      @(negedge clk);
      checks++;
      if (bus.md_stall !== ((c >= 3) && (c <= 11))) begin
        failures++;
        $display("FAIL mfhi_stall cycle=%0d got=%b want=%b", c, bus.md_stall, ((c >= 3) && (c <= 11)));
      end
      if (bus.md_start) start_n++;
      if (c == 12) begin
        checks++;
        if (bus.md_busy !== 1'b0) begin
          failures++;
          $display("FAIL mfhi_idle got busy=%b want=0", bus.md_busy);
        end
      end
      nxt();
    end
    checks++;
    if (start_n !== 0) begin
      failures++;
      $display("FAIL mfhi_nostart got=%0d want=0", start_n);
    end
    quiet_inputs();
  endtask

  task automatic test_back_to_back();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b100;
    nxt();
    for (int c = 1; c <= 11; c++) begin
      bus.md_run   = (c <= 5) || ((c >= 8) && (c <= 9));
      bus.md_req_E = (c >= 3) && (c <= 7);
      bus.md_op_E  = ((c >= 3) && (c <= 7)) ? 3'b110 : 3'b000;
      @(negedge clk);
      checks++;
      if (bus.md_stall !== ((c >= 3) && (c <= 6)) || bus.md_start !== (c == 7)) begin
        failures++;
        $display("FAIL b2b_hs cycle=%0d got stall=%b start=%b want stall=%b start=%b",
                 c, bus.md_stall, bus.md_start, ((c >= 3) && (c <= 6)), (c == 7));
      end
      if (c == 7) begin
        checks++;
        if (bus.md_cycles !== 6'd6 || bus.md_op !== 3'b100) begin
          failures++;
          $display("FAIL b2b_first got cycles=%0d op=%b want 6 100", bus.md_cycles, bus.md_op);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.md_op !== 3'b110 || bus.md_busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_second got op=%b busy=%b want 110 1", bus.md_op, bus.md_busy);
        end
      end
      if (c == 11) begin
        checks++;
        if (bus.md_busy !== 1'b0 || bus.md_cycles !== 6'd3) begin
          failures++;
          $display("FAIL b2b_done got busy=%b cycles=%0d want 0 3", bus.md_busy, bus.md_cycles);
        end
      end
      nxt();
    end
    quiet_inputs();
  endtask

  task automatic test_flush();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b101;
    bus.flush_E  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.md_start !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_start got=%b want=0", bus.md_start);
    end
    nxt();
    quiet_inputs();
    @(negedge clk);
    checks++;
    if (bus.md_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_state got busy=%b want=0", bus.md_busy);
    end
    nxt();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b001;
    nxt();
    bus.md_req_E = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      bus.md_run  = (c <= 3);
      bus.flush_E = (c >= 2) && (c <= 4);
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if (bus.md_busy !== 1'b0 || bus.md_cycles !== 6'd4 || bus.md_op !== 3'b001) begin
          failures++;
          $display("FAIL flush_busy got busy=%b cycles=%0d op=%b want 0 4 001",
                   bus.md_busy, bus.md_cycles, bus.md_op);
        end
      end
      nxt();
    end
    quiet_inputs();
  endtask

  task automatic test_min_occupancy();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b111;
    nxt();
    quiet_inputs();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.md_busy !== (c <= 2)) begin
        failures++;
        $display("FAIL min_busy cycle=%0d got=%b want=%b", c, bus.md_busy, (c <= 2));
      end
      if (c == 3) begin
        checks++;
        if (bus.md_cycles !== 6'd2) begin
          failures++;
          $display("FAIL min_cycles got=%0d want=2", bus.md_cycles);
        end
      end
      nxt();
    end
  endtask

`ifdef MD_TIMEOUT_EN
  task automatic test_timeout();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b011;
    nxt();
    bus.md_req_E = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      bus.md_run    = 1'b1;
      bus.hilo_rd_E = (c >= 3);
      @(negedge clk);
      checks++;
      if (bus.md_stall !== ((c >= 3) && (c <= 8))) begin
        failures++;
        $display("FAIL tmo_stall cycle=%0d got=%b want=%b", c, bus.md_stall, ((c >= 3) && (c <= 8)));
      end
      if (c == 8) begin
        checks++;
        if (bus.md_err !== 1'b0 || bus.md_busy !== 1'b1) begin
          failures++;
          $display("FAIL tmo_early got err=%b busy=%b want 0 1", bus.md_err, bus.md_busy);
        end
      end
      if (c == 9) begin
        checks++;
        if (bus.md_err !== 1'b1 || bus.md_busy !== 1'b0 || bus.md_cycles !== 6'd8) begin
          failures++;
          $display("FAIL tmo_abort got err=%b busy=%b cycles=%0d want 1 0 8",
                   bus.md_err, bus.md_busy, bus.md_cycles);
        end
      end
      nxt();
    end
    quiet_inputs();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b010;
    @(negedge clk);
    checks++;
    if (bus.md_start !== 1'b1) begin
      failures++;
      $display("FAIL tmo_accept got start=%b want=1", bus.md_start);
    end
    nxt();
    bus.md_req_E = 1'b0;
    for (int c = 11; c <= 14; c++) begin
      bus.md_run = (c <= 12);
      @(negedge clk);
      if (c == 14) begin
        checks++;
        if (bus.md_err !== 1'b1 || bus.md_busy !== 1'b0 || bus.md_cycles !== 6'd3) begin
          failures++;
          $display("FAIL tmo_sticky got err=%b busy=%b cycles=%0d want 1 0 3",
                   bus.md_err, bus.md_busy, bus.md_cycles);
        end
      end
      nxt();
    end
    quiet_inputs();
    reset = 1'b0;
    #2;
    checks++;
    if (bus.md_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got err=%b want=0", bus.md_err);
    end
    @(negedge clk);
    reset = 1'b1;
    nxt();
  endtask
`else
  task automatic test_saturate();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b011;
    nxt();
    bus.md_req_E = 1'b0;
    for (int c = 1; c <= 72; c++) begin
      bus.md_run = (c <= 69);
      @(negedge clk);
      if (c == 72) begin
        checks++;
        if (bus.md_busy !== 1'b0 || bus.md_cycles !== 6'd63 || bus.md_err !== 1'b0) begin
          failures++;
          $display("FAIL sat_cycles got busy=%b cycles=%0d err=%b want 0 63 0",
                   bus.md_busy, bus.md_cycles, bus.md_err);
        end
      end
      nxt();
    end
    quiet_inputs();
  endtask
`endif

  task automatic test_reset_midop();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b101;
    nxt();
    bus.md_req_E = 1'b0;
    bus.md_run   = 1'b1;
    repeat (3) nxt();
    bus.md_req_E  = 1'b1;
    bus.md_op_E   = 3'b011;
    bus.hilo_rd_E = 1'b1;
    #1;
    checks++;
    if (bus.md_stall !== 1'b1 || bus.md_busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got stall=%b busy=%b want 1 1", bus.md_stall, bus.md_busy);
    end
    reset = 1'b0;
    #2;
    checks++;
    if ({bus.md_busy, bus.md_stall, bus.md_start, bus.md_err} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_async_ctrl got=%b want=0000", {bus.md_busy, bus.md_stall, bus.md_start, bus.md_err});
    end
    checks++;
    if (bus.md_op !== 3'b000 || bus.md_cycles !== 6'd0) begin
      failures++;
      $display("FAIL rst_async_data got op=%b cycles=%0d want 000 0", bus.md_op, bus.md_cycles);
    end
    quiet_inputs();
    @(negedge clk);
    reset = 1'b1;
    nxt();
    bus.md_req_E = 1'b1;
    bus.md_op_E  = 3'b011;
    @(negedge clk);
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_release got start=%b stall=%b want 1 0", bus.md_start, bus.md_stall);
    end
    nxt();
    quiet_inputs();
    repeat (3) nxt();
  endtask

  initial begin
    quiet_inputs();
    test_reset();
    test_basic_mult();
    test_stalled_mfhi();
    test_back_to_back();
    test_flush();
    test_min_occupancy();
`ifdef MD_TIMEOUT_EN
    test_timeout();
`else
    test_saturate();
`endif
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got=expired want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
